data_mem_be: RTL and testbench

- Parametrised successor to the single-cycle data memory for the RV32 datapath.
- Adds byte/halfword/word stores with byte enables, signed/unsigned load extension, and misalignment/illegal-size fault reporting.
- Uses a registered 1-cycle read and a counter-driven post-reset clear sweep with a ready handshake, replacing the single-cycle array reset.
- Sits between the ALU address path and the writeback mux.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_lane_align.sv | 54 +++++
 rtl/data_mem_be.sv | 165 ++++++++++++++++
 tb/tb_data_mem_be.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, funct3 codes and access-legality helpers for data_mem_be
package dmem_pkg;

  // Controller state: post-reset clear sweep, then open for accesses
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // RV32 load/store size and sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Halfwords need an even address, words a multiple of four; bytes always fit
  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic ok;
    case (funct3)
      F3_H, F3_HU: ok = ~addr_lo[0];
      F3_W:        ok = (addr_lo == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Unsigned variants only exist for loads; every other code is rejected
  function automatic logic is_legal(input logic [2:0] funct3, input logic is_store);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and load extraction/extension
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [3:0]      byte_en_o,
  output logic [XLEN-1:0] wdata_lane_o,
  output logic [XLEN-1:0] rdata_ext_o
);

  // Selected byte/halfword moved down to bit 0 before extension
  logic [XLEN-1:0] shifted;
  assign shifted = raw_i >> {addr_lo_i, 3'b000};

  // Store path: replicate the right-aligned data across lanes, enable only the target lanes
  always_comb begin
    byte_en_o    = 4'b0000;
    wdata_lane_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        byte_en_o    = 4'b0001 << addr_lo_i;
        wdata_lane_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        byte_en_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_lane_o = {2{wdata_i[15:0]}};
      end
      F3_W: begin
        byte_en_o    = 4'b1111;
      end
      default: begin
        byte_en_o    = 4'b0000;
      end
    endcase
  end

  // Load path: sign- or zero-extend the extracted field
  always_comb begin
    rdata_ext_o = raw_i;
    case (funct3_i)
      F3_B:    rdata_ext_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   rdata_ext_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_H:    rdata_ext_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   rdata_ext_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: rdata_ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/data_mem_be.sv
// rtl/data_mem_be.sv - byte-enabled RV32 data memory with registered loads and reset clear sweep
module data_mem_be
  import dmem_pkg::*;
#(
  parameter int    XLEN           = 32,
  parameter int    DEPTH          = 256,
  parameter int    ADDR_W         = 32,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              rdata_valid,
  output logic              fault,
  output logic              init_busy
);

  localparam int IDX_W = $clog2(DEPTH);

  // Parameter sanity, caught at elaboration
  if (XLEN != 32) begin : g_bad_xlen
    $error("data_mem_be: XLEN must be 32");
  end
  if ((DEPTH < 4) || ((1 << IDX_W) != DEPTH)) begin : g_bad_depth
    $error("data_mem_be: DEPTH must be a power of two and at least 4");
  end
  if (CLEAR_ON_RESET && (INIT_FILE != "")) begin : g_init_cleared
    $warning("data_mem_be: INIT_FILE contents are wiped by the clear sweep");
  end

  logic [XLEN-1:0]  mem_q [DEPTH];

  state_t           state_q;
  logic [IDX_W-1:0] clr_cnt_q;
  logic [IDX_W-1:0] clr_cnt_d;
  logic             ready_q;
  logic             busy_q;
  logic [XLEN-1:0]  rdata_q;
  logic             rdata_valid_q;
  logic             fault_q;

  // Address split: word index plus byte lane; upper bits alias
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       addr_lo;
  logic             unused_addr_hi;
  assign word_idx       = addr[IDX_W+1:2];
  assign addr_lo        = addr[1:0];
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W+2];

  // Request qualification
  logic accept;
  logic active;
  logic bad_req;
  logic do_fault;
  logic do_store;
  logic do_load;
  assign accept   = req_valid & req_ready;
  assign active   = mem_read | mem_write;
  assign bad_req  = (mem_read & mem_write)
                  | ~is_legal(funct3, mem_write)
                  | ~is_aligned(funct3, addr_lo);
  assign do_fault = accept & active & bad_req;
  assign do_store = accept & mem_write & ~bad_req;
  assign do_load  = accept & mem_read & ~bad_req;

  // Lane steering for both directions
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] raw_word;
  logic [XLEN-1:0] load_ext;
  assign raw_word = mem_q[word_idx];

  dmem_lane_align #(
    .XLEN (XLEN)
  ) u_lane_align (
    .funct3_i     (funct3),
    .addr_lo_i    (addr_lo),
    .wdata_i      (wdata),
    .raw_i        (raw_word),
    .byte_en_o    (lane_be),
    .wdata_lane_o (lane_wdata),
    .rdata_ext_o  (load_ext)
  );

  assign clr_cnt_d = clr_cnt_q + IDX_W'(1);

  // Array write port: the sweep owns it in CLEAR, accepted stores own it in READY
  logic [3:0]       wr_be;
  logic [IDX_W-1:0] wr_idx;
  logic [XLEN-1:0]  wr_data;
  always_comb begin
    wr_be   = 4'b0000;
    wr_idx  = word_idx;
    wr_data = lane_wdata;
    if ((state_q == CLEAR) && !rst) begin
      wr_be   = 4'b1111;
      wr_idx  = clr_cnt_q;
      wr_data = '0;
    end else if (do_store) begin
      wr_be   = lane_be;
    end
  end

  // Storage with per-byte write enables; deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) begin
        mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Controller FSM with registered handshake, status and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_cnt_q     <= '0;
      ready_q       <= ~CLEAR_ON_RESET;
      busy_q        <= CLEAR_ON_RESET;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_d;
          if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q <= READY;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          if (do_fault) begin
            fault_q <= 1'b1;
          end else if (do_load) begin
            rdata_q       <= load_ext;
            rdata_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  // The ready flag is forced low for as long as reset is held
  assign req_ready   = ready_q & ~rst;
  assign init_busy   = busy_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_data_mem_be.sv
// tb/tb_data_mem_be.sv - scoreboard bench for data_mem_be against a byte-array reference model
module tb_data_mem_be;

  localparam int DEPTH = 256;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        fault;
  logic        init_busy;

  data_mem_be #(
    .XLEN           (32),
    .DEPTH          (DEPTH),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1'b1),
    .INIT_FILE      ("")
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .init_busy   (init_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    bit          is_fault;
    bit          is_load;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] exp_last = '0;
  logic [2:0]  legal_codes [5] = '{LB, LH, LW, LBU, LHU};
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory as a flat byte array, accesses judged by size and code
  task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    int          size;
    int          ba;
    bit          legal;
    logic [31:0] v;
    exp_t        e;
    if (!rd && !wr) return;
    size  = 1 << f3[1:0];
    legal = !(rd && wr);
    if (wr) legal &= (f3 == LB || f3 == LH || f3 == LW);
    else    legal &= (f3 inside {LB, LH, LW, LBU, LHU});
    legal &= ((a % size) == 0);
    ba         = int'(a % (DEPTH * 4));
    e.due      = cyc + 1;
    e.is_fault = 1'b0;
    e.is_load  = 1'b0;
    e.data     = '0;
    if (!legal) begin
      e.is_fault = 1'b1;
      sb.push_back(e);
    end else if (wr) begin
      for (int i = 0; i < size; i++) ref_mem[ba + i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) v |= 32'(ref_mem[ba + i]) << (8 * i);
      if (!f3[2] && size < 4 && v[8*size-1]) v |= ~((32'd1 << (8 * size)) - 32'd1);
      e.is_load = 1'b1;
      e.data    = v;
      sb.push_back(e);
    end
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    model(rd, wr, f3, a, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    sb.delete();
    exp_last  = '0;
    for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h00;
    repeat (hold) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  // Counts sweep cycles from release while a load is held on the ignored request port
  task automatic sweep_check();
    int n;
    n         = 0;
    req_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    funct3    = LW;
    addr      = 32'h0;
    while (init_busy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_busy) chk("busy_ready_low", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    mem_read  = 1'b0;
    chk("sweep_len", n, 32'd256);
    chk("ready_after_sweep", 32'(req_ready), 32'd1);
  endtask

  // Monitor: pops the scoreboard on the cycle a response is due, otherwise demands silence
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("fault", 32'(fault), 32'(e.is_fault));
        chk("rdata_valid", 32'(rdata_valid), 32'(e.is_load));
        if (e.is_load) begin
          chk("rdata", rdata, e.data);
          exp_last = e.data;
        end else begin
          chk("rdata_hold", rdata, exp_last);
        end
      end else begin
        chk("no_pulse", {30'd0, rdata_valid, fault}, 32'd0);
        chk("rdata_hold", rdata, exp_last);
      end
    end
  end

  initial begin
    int          op;
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;

    rst       = 1'b0;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;

    do_reset(3);
    sweep_check();
    access(1, 0, LW, 32'h3FC, 32'h0);

    access(0, 1, LW, 32'h10, 32'hDEADBEEF);
    access(0, 1, LB, 32'h11, 32'h00000080);
    access(1, 0, LB, 32'h11, 32'h0);
    access(1, 0, LBU, 32'h11, 32'h0);
    access(1, 0, LW, 32'h10, 32'h0);

    access(0, 1, LH, 32'h22, 32'h00008001);
    access(1, 0, LH, 32'h22, 32'h0);
    access(1, 0, LHU, 32'h22, 32'h0);
    access(1, 0, LW, 32'h20, 32'h0);

    access(1, 0, LW, 32'h13, 32'h0);
    access(0, 1, LH, 32'h21, 32'hFFFF);
    access(0, 1, LBU, 32'h11, 32'h55);
    access(1, 0, LW, 32'h10, 32'h0);
    idle(3);

    do_reset(2);
    repeat (100) @(posedge clk);
    do_reset(2);
    sweep_check();
    access(0, 1, LW, 32'h400, 32'h5);
    access(1, 0, LW, 32'h0, 32'h0);

    access(0, 1, LW, 32'h40, 32'h12345678);
    access(1, 0, LW, 32'h40, 32'h0);
    access(1, 1, LW, 32'h40, 32'hFFFFFFFF);
    access(0, 0, LW, 32'h40, 32'hAAAAAAAA);
    access(1, 0, LW, 32'h40, 32'h0);
    idle(2);

    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      rd = (op < 4) || (op == 8);
      wr = (op >= 4 && op < 8) || (op == 8);
      if ($urandom_range(0, 3) != 0) f3 = legal_codes[$urandom_range(0, 4)];
      else                           f3 = 3'($urandom);
      if ($urandom_range(0, 4) == 0) a = $urandom;
      else                           a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      wd = $urandom;
      access(rd, wr, f3, a, wd);
      if ($urandom_range(0, 5) == 0) idle(1);
    end
    idle(4);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
